alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
Registered decode stage that turns RV32I integer-compute instructions into the 4-bit function-select code, operand selects and immediate consumed by the execute-stage function unit. It sits between instruction fetch and execute and uses a valid/ready handshake on both sides. One output register stage is provided, with a flush input for branch/jump redirects.

Parameters:
XLEN, 32, datapath and immediate width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  drops the held output and any same-cycle input
in_valid  input  1  instruction and pc are valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction
in_pc  input  32  instruction address
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute stage accepts bundle
out_fs  output  4  function select code
out_a_sel  output  2  operand A: 00=rs1, 01=pc, 10=zero
out_b_sel  output  1  operand B: 0=rs2, 1=imm
out_imm  output  32  decoded immediate
out_rs1  output  5  source register 1 index
out_rs2  output  5  source register 2 index
out_rd  output  5  destination register index
out_reg_write  output  1  result is written back
out_illegal  output  1  instruction not decodable by this stage
out_pc  output  32  pc carried along with the bundle

Behaviour:
- Reset (async, active-high): out_valid=0; every other output register = 0; out_fs=0000 (ADD).
- in_ready = !out_valid || out_ready. This path is combinational and there is no skid buffer.
- Input transfer when in_valid && in_ready. The decoded bundle is registered and out_valid=1 from the next cycle; latency is 1 cycle.
- Output transfer when out_valid && out_ready. If no new transfer occurs in the same cycle, out_valid clears next cycle.
- Back-to-back: transfers on both sides in the same cycle give full throughput, one instruction per cycle.
- Stall: while out_valid && !out_ready, every out_* is held stable.
- flush=1 has priority over everything: out_valid=0 next cycle and any same-cycle input transfer is discarded. in_ready still follows the formula above.
- FS encodings:
  - ADD=0000, SUB=0001, SLL=0010, SLT=0100, SLTU=0110
  - XOR=1000, SRL=1010, SRA=1011, OR=1100, AND=1110
- OP (0110011):
  - fs={funct3, funct7[5]}.
  - funct7 must be 0000000, or 0100000 only with funct3 000 or 101; anything else is illegal.
  - a_sel=rs1, b_sel=rs2.
- OP-IMM (0010011):
  - a_sel=rs1, b_sel=imm.
  - funct3 001/101 (shifts): imm = zero-extended shamt[24:20]; fs={funct3, instr[30]}.
  - SLLI requires instr[31:25]=0000000; SRLI/SRAI require 0000000 or 0100000; otherwise illegal.
  - Other funct3: fs={funct3, 0}; imm = sign-extended instr[31:20].
- LUI (0110111): fs=ADD, a_sel=zero, b_sel=imm, imm={instr[31:12], 12'b0}.
- AUIPC (0010111): fs=ADD, a_sel=pc, b_sel=imm, imm as for LUI.
- Any other opcode, or instr[1:0]!=11, is illegal.
- Illegal instructions: out_illegal=1, reg_write=0, fs=ADD, imm=0, selects=0. The bundle is still passed downstream with valid.
- reg_write = legal && rd!=0.
- rs1/rs2/rd are always the raw fields [19:15]/[24:20]/[11:7], including for illegal instructions.
- Reset asserted mid-stall clears out_valid immediately (asynchronously); the bundle is lost.

Decomposition:
- Shared package alu_pkg:
  - FS code constants.
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - A-select constants.
  - FS_WIDTH=4.
  - The function unit should adopt the same constants.
- Sub-module alu_op_decode_comb: purely combinational instruction-to-bundle decode. The top level holds the handshake and the output register.

Test Plan:
- After reset, in_valid=1 with 0x40B50533 (sub x10,x10,x11) and out_ready=1 -> next cycle: out_valid=1, fs=0001, a_sel=00, b_sel=0, rs1=10, rs2=11, rd=10, reg_write=1, illegal=0.
- 0x40335293 (srai x5,x6,3) -> fs=1011, b_sel=1, imm=0x00000003, rd=5. Then 0xFFF00093 (addi x1,x0,-1) -> fs=0000, imm=0xFFFFFFFF.
- 0x12345137 (lui x2,0x12345) -> fs=0000, a_sel=10, imm=0x12345000. Then auipc with in_pc=0x100 -> a_sel=01, out_pc=0x100.
- 0x02B50533 (mul encoding) -> illegal=1, reg_write=0, fs=0000. Also addi with rd=0 -> reg_write=0, illegal=0.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Release -> bundles delivered in order with none lost or duplicated.
- flush=1 in the same cycle as an input transfer -> out_valid=0 next cycle and the instruction never appears. A transfer in the following cycle proceeds normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the integer function unit and its decode stage.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FS_WIDTH = 4;

  // Function-select codes; the function unit decodes the same values.
  localparam logic [FS_WIDTH-1:0] FS_ADD  = 4'b0000;
  localparam logic [FS_WIDTH-1:0] FS_SUB  = 4'b0001;
  localparam logic [FS_WIDTH-1:0] FS_SLL  = 4'b0010;
  localparam logic [FS_WIDTH-1:0] FS_SLT  = 4'b0100;
  localparam logic [FS_WIDTH-1:0] FS_SLTU = 4'b0110;
  localparam logic [FS_WIDTH-1:0] FS_XOR  = 4'b1000;
  localparam logic [FS_WIDTH-1:0] FS_SRL  = 4'b1010;
  localparam logic [FS_WIDTH-1:0] FS_SRA  = 4'b1011;
  localparam logic [FS_WIDTH-1:0] FS_OR   = 4'b1100;
  localparam logic [FS_WIDTH-1:0] FS_AND  = 4'b1110;

  // Major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Operand A source selects.
  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  // Decoded bundle handed to the execute stage (pc travels separately).
  typedef struct packed {
    logic [FS_WIDTH-1:0] fs;
    logic [1:0]          a_sel;
    logic                b_sel;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                reg_write;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational RV32I integer-compute decode: instruction word to bundle.
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  output dec_bundle_t  bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Field decode; illegal encodings collapse to an all-zero operation.
  always_comb begin
    logic legal;
    legal            = 1'b0;
    bundle.fs        = FS_ADD;
    bundle.a_sel     = ASEL_RS1;
    bundle.b_sel     = 1'b0;
    bundle.imm       = '0;
    bundle.rs1       = instr[19:15];
    bundle.rs2       = instr[24:20];
    bundle.rd        = instr[11:7];

    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: begin
          legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
          bundle.fs = {funct3, funct7[5]};
        end
        OPC_OP_IMM: begin
          bundle.b_sel = 1'b1;
          if (funct3 == 3'b001) begin
            legal      = (funct7 == 7'b0000000);
            bundle.fs  = {funct3, instr[30]};
            bundle.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
          end else if (funct3 == 3'b101) begin
            legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            bundle.fs  = {funct3, instr[30]};
            bundle.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
          end else begin
            legal      = 1'b1;
            bundle.fs  = {funct3, 1'b0};
            bundle.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
          end
        end
        OPC_LUI: begin
          legal        = 1'b1;
          bundle.a_sel = ASEL_ZERO;
          bundle.b_sel = 1'b1;
          bundle.imm   = {instr[31:12], 12'b0};
        end
        OPC_AUIPC: begin
          legal        = 1'b1;
          bundle.a_sel = ASEL_PC;
          bundle.b_sel = 1'b1;
          bundle.imm   = {instr[31:12], 12'b0};
        end
        default: legal = 1'b0;
      endcase
    end

    if (!legal) begin
      bundle.fs    = FS_ADD;
      bundle.a_sel = ASEL_RS1;
      bundle.b_sel = 1'b0;
      bundle.imm   = '0;
    end

    bundle.illegal   = !legal;
    bundle.reg_write = legal && (bundle.rd != 5'd0);
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered decode stage with valid/ready handshake and redirect flush.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int unsigned XLEN_P = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN_P-1:0]   in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FS_WIDTH-1:0] out_fs,
  output logic [1:0]          out_a_sel,
  output logic                out_b_sel,
  output logic [XLEN_P-1:0]   out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_reg_write,
  output logic                out_illegal,
  output logic [XLEN_P-1:0]   out_pc
);

  dec_bundle_t        dec;
  dec_bundle_t        bundle_q;
  logic [XLEN_P-1:0]  pc_q;
  logic               valid_q;
  logic               in_fire;

  alu_op_decode_comb u_decode (
    .instr  (in_instr),
    .bundle (dec)
  );

  // No skid buffer: accept only when the output slot is empty or draining.
  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Output register; flush wins over both load and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_fire) begin
      valid_q  <= 1'b1;
      bundle_q <= dec;
      pc_q     <= in_pc;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_fs        = bundle_q.fs;
  assign out_a_sel     = bundle_q.a_sel;
  assign out_b_sel     = bundle_q.b_sel;
  assign out_imm       = bundle_q.imm[XLEN_P-1:0];
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd        = bundle_q.rd;
  assign out_reg_write = bundle_q.reg_write;
  assign out_illegal   = bundle_q.illegal;
  assign out_pc        = pc_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_fs;
  logic [1:0]  out_a_sel;
  logic        out_b_sel;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;
  logic [31:0] out_pc;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_fs        (out_fs),
    .out_a_sel     (out_a_sel),
    .out_b_sel     (out_b_sel),
    .out_imm       (out_imm),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle with out_ready high.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_fs, out_a_sel, out_b_sel, out_imm, out_rs1, out_rs2, out_rd, out_reg_write,
                  out_illegal, out_pc} !== '0) begin
      n_bad++; $display("FAIL reset_regs got fs=%b imm=%h pc=%h want all zero", out_fs, out_imm, out_pc);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_op();
    send(32'h40B50533, 32'h0000_0040);  // sub x10,x10,x11
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sub_valid got %b want 1", out_valid); end
    n_cmp++; if (out_fs !== 4'b0001) begin n_bad++; $display("FAIL sub_fs got %b want 0001", out_fs); end
    n_cmp++; if ({out_a_sel, out_b_sel} !== 3'b000) begin
      n_bad++; $display("FAIL sub_sel got %b want 000", {out_a_sel, out_b_sel}); end
    n_cmp++; if ({out_rs1, out_rs2, out_rd} !== {5'd10, 5'd11, 5'd10}) begin
      n_bad++; $display("FAIL sub_regs got %0d/%0d/%0d want 10/11/10", out_rs1, out_rs2, out_rd); end
    n_cmp++; if ({out_reg_write, out_illegal} !== 2'b10) begin
      n_bad++; $display("FAIL sub_flags got %b want 10", {out_reg_write, out_illegal}); end
    n_cmp++; if (out_pc !== 32'h40) begin n_bad++; $display("FAIL sub_pc got %h want 40", out_pc); end
    send(32'h0020F1B3, 32'h0);  // and x3,x1,x2
    n_cmp++; if (out_fs !== 4'b1110) begin n_bad++; $display("FAIL and_fs got %b want 1110", out_fs); end
    n_cmp++; if (out_rd !== 5'd3) begin n_bad++; $display("FAIL and_rd got %0d want 3", out_rd); end
  endtask

  task automatic test_op_imm();
    send(32'h40335293, 32'h0);  // srai x5,x6,3
    n_cmp++; if (out_fs !== 4'b1011) begin n_bad++; $display("FAIL srai_fs got %b want 1011", out_fs); end
    n_cmp++; if (out_b_sel !== 1'b1) begin n_bad++; $display("FAIL srai_bsel got %b want 1", out_b_sel); end
    n_cmp++; if (out_imm !== 32'h3) begin n_bad++; $display("FAIL srai_imm got %h want 3", out_imm); end
    n_cmp++; if ({out_rs1, out_rd} !== {5'd6, 5'd5}) begin
      n_bad++; $display("FAIL srai_regs got %0d/%0d want 6/5", out_rs1, out_rd); end
    send(32'hFFF00093, 32'h0);  // addi x1,x0,-1
    n_cmp++; if (out_fs !== 4'b0000) begin n_bad++; $display("FAIL addi_fs got %b want 0000", out_fs); end
    n_cmp++; if (out_imm !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
    n_cmp++; if (out_reg_write !== 1'b1) begin
      n_bad++; $display("FAIL addi_rw got %b want 1", out_reg_write); end
    send(32'hFFE0B213, 32'h0);  // sltiu x4,x1,-2
    n_cmp++; if ({out_fs, out_imm} !== {4'b0110, 32'hFFFFFFFE}) begin
      n_bad++; $display("FAIL sltiu got fs=%b imm=%h want 0110/fffffffe", out_fs, out_imm); end
    send(32'h00109093, 32'h0);  // slli x1,x1,1
    n_cmp++; if ({out_fs, out_imm, out_illegal} !== {4'b0010, 32'h1, 1'b0}) begin
      n_bad++; $display("FAIL slli got fs=%b imm=%h ill=%b want 0010/1/0", out_fs, out_imm, out_illegal); end
    send(32'h40109093, 32'h0);  // slli with funct7=0100000: illegal
    n_cmp++; if ({out_illegal, out_fs, out_imm} !== {1'b1, 4'b0000, 32'h0}) begin
      n_bad++; $display("FAIL slli_bad got ill=%b fs=%b imm=%h want 1/0000/0", out_illegal, out_fs, out_imm); end
  endtask

  task automatic test_upper();
    send(32'h12345137, 32'h0);  // lui x2,0x12345
    n_cmp++; if ({out_fs, out_a_sel, out_b_sel} !== {4'b0000, 2'b10, 1'b1}) begin
      n_bad++; $display("FAIL lui_ctl got fs=%b a=%b b=%b want 0000/10/1", out_fs, out_a_sel, out_b_sel); end
    n_cmp++; if (out_imm !== 32'h12345000) begin n_bad++; $display("FAIL lui_imm got %h want 12345000", out_imm); end
    send(32'h00001197, 32'h100);  // auipc x3,0x1
    n_cmp++; if ({out_a_sel, out_b_sel} !== 3'b011) begin
      n_bad++; $display("FAIL auipc_sel got %b want 011", {out_a_sel, out_b_sel}); end
    n_cmp++; if (out_pc !== 32'h100) begin n_bad++; $display("FAIL auipc_pc got %h want 100", out_pc); end
    n_cmp++; if ({out_imm, out_rd} !== {32'h1000, 5'd3}) begin
      n_bad++; $display("FAIL auipc_imm got %h rd=%0d want 1000/3", out_imm, out_rd); end
  endtask

  task automatic test_illegal();
    send(32'h02B50533, 32'h0);  // mul x10,x10,x11
    n_cmp++; if ({out_valid, out_illegal, out_reg_write, out_fs} !== {1'b1, 1'b1, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL mul got v=%b ill=%b rw=%b fs=%b want 1/1/0/0000",
                        out_valid, out_illegal, out_reg_write, out_fs); end
    n_cmp++; if ({out_rs1, out_rs2, out_rd} !== {5'd10, 5'd11, 5'd10}) begin
      n_bad++; $display("FAIL mul_regs got %0d/%0d/%0d want 10/11/10", out_rs1, out_rs2, out_rd); end
    send(32'h00000000, 32'h0);  // low bits != 11
    n_cmp++; if (out_illegal !== 1'b1) begin n_bad++; $display("FAIL zero_ill got %b want 1", out_illegal); end
    send(32'h00500013, 32'h0);  // addi x0,x0,5
    n_cmp++; if ({out_reg_write, out_illegal, out_imm} !== {1'b0, 1'b0, 32'h5}) begin
      n_bad++; $display("FAIL addi_x0 got rw=%b ill=%b imm=%h want 0/0/5", out_reg_write, out_illegal, out_imm); end
  endtask

  task automatic test_stall();
    logic [4:0] got [$];
    int         waited;
    send(32'h00100093, 32'h0);  // addi x1,x0,1 now held in the output slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00200113;   // addi x2,x0,2 waits upstream
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd1, 32'h1}) begin
        n_bad++; $display("FAIL stall_hold%0d got v=%b rd=%0d imm=%h want 1/1/1", i, out_valid, out_rd, out_imm); end
    end
    got.push_back(out_rd);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b want 1", in_ready); end
    step();                     // x1 drains, x2 loads in the same edge
    in_valid = 1'b1;
    in_instr = 32'h00300193;    // addi x3,x0,3 back-to-back
    if (out_valid) got.push_back(out_rd);
    step();
    in_valid = 1'b0;
    if (out_valid) got.push_back(out_rd);
    waited = 0;
    step();
    while (out_valid && waited < 4) begin
      got.push_back(out_rd);
      step();
      waited++;
    end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL stall_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 5'(i + 1)) begin
        n_bad++; $display("FAIL stall_order%0d got rd=%0d want %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00700393;  // addi x7,x0,7 discarded by flush
    flush     = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", out_valid); end
    in_instr = 32'h00800413;   // addi x8,x0,8
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_rd} !== {1'b1, 5'd8}) begin
      n_bad++; $display("FAIL after_flush got v=%b rd=%0d want 1/8", out_valid, out_rd); end
    out_ready = 1'b0;
    flush     = 1'b1;          // flush a stalled bundle
    step();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_held got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    send(32'h00900493, 32'h0);  // addi x9,x0,9
    out_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_upper();
    test_illegal();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
